// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_PE processing elements.
// One access in flight at a time; a stalled access is aborted with an error after TIMEOUT cycles.
module pe_mem_arbiter #(
  parameter int NUM_PE  = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PE-1:0]          pe_mem_read,
  input  logic [NUM_PE-1:0]          pe_mem_write,
  input  logic [NUM_PE*ADDR_W-1:0]   pe_mem_address,
  input  logic [NUM_PE*DATA_W-1:0]   pe_mem_wdata,
  input  logic [NUM_PE*2-1:0]        pe_mem_size,
  output logic [NUM_PE-1:0]          pe_mem_ack,
  output logic [DATA_W-1:0]          pe_mem_rdata,
  output logic                       pe_mem_err,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [1:0]                 mem_size,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(NUM_PE)-1:0]  grant_id,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_PE);
  localparam int IW1 = IDW + 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;

  logic [NUM_PE-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_PE-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_PE-1:0][1:0]        size_a;
  logic [NUM_PE-1:0]             req;
  logic [IDW-1:0]                rr_ptr, winner;
  logic [IW1-1:0]                idx;
  logic [CW-1:0]                 tmo_cnt;
  logic                          tmo_hit, acc_end;

  assign addr_a  = pe_mem_address;
  assign wdata_a = pe_mem_wdata;
  assign size_a  = pe_mem_size;
  assign req     = pe_mem_read | pe_mem_write;
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));
  assign acc_end = (state == ACCESS) && (mem_ack || tmo_hit);
  assign busy    = (state != IDLE);

  // Walk offsets from farthest to nearest so the nearest requester to rr_ptr wins.
  always_comb begin
    winner = rr_ptr;
    idx    = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + IW1'(k);
      if (idx >= IW1'(NUM_PE)) idx = idx - IW1'(NUM_PE);
      if (req[idx[IDW-1:0]]) winner = idx[IDW-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = ACCESS;
      ACCESS:  if (acc_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_mem_ack   <= '0;
      pe_mem_rdata <= '0;
      pe_mem_err   <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_size     <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
      tmo_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant_id    <= winner;
          mem_address <= addr_a[winner];
          mem_wdata   <= wdata_a[winner];
          mem_size    <= size_a[winner];
          // A PE raising both strobes is treated as a store.
          mem_write   <= pe_mem_write[winner];
          mem_read    <= ~pe_mem_write[winner];
          tmo_cnt     <= '0;
        end
        ACCESS: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (acc_end) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            pe_mem_ack <= NUM_PE'(1) << grant_id;
            pe_mem_err <= ~mem_ack;
            if (mem_ack && !mem_write) pe_mem_rdata <= mem_rdata;
          end
        end
        DONE: begin
          pe_mem_ack <= '0;
          pe_mem_err <= 1'b0;
          rr_ptr     <= (grant_id == IDW'(NUM_PE - 1)) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
